ber_frame_ctrl: RTL and testbench
=================================

// Module: ber_frame_ctrl
// PURPOSE
//  Frame-level bit-error controller wrapped around the 12-bit Hamming comparator (bit_com).
//  - Accepts a frame of N (info, estimate) word pairs over a valid/ready handshake.
//  - Registers each per-word distance and accumulates the frame's total bit errors and worst-word distance.
//  - Reports a pass/fail verdict against a threshold. Sits between the decoder test source and the result/report logic.
// PARAMETERS
//  WORD_W   12   word width; fixed to bit_com width, 12 only
//  LEN_W    10   width of frame_len / word_cnt (max 1023 words per frame)
//  ERR_W    16   width of err_total accumulator
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      asynchronous, active-low reset
//  start      in   1      1-cycle pulse; begins a frame (honoured only in IDLE or DONE)
//  frame_len  in   LEN_W  words in frame; sampled when start is accepted
//  err_thresh in   ERR_W  fail threshold; sampled when start is accepted
//  in_valid   in   1      info_bits/esti_bits valid
//  in_ready   out  1      controller accepts a pair this cycle
//  info_bits  in   12     transmitted word
//  esti_bits  in   12     decoded word
//  busy       out  1      frame in progress (RUN or FLUSH)
//  done       out  1      1-cycle pulse: results valid
//  word_cnt   out  LEN_W  pairs accepted in current/last frame
//  err_total  out  ERR_W  summed Hamming distance, saturating at all-ones
//  max_dist   out  4      largest single-word distance in frame (0..12)
//  fail       out  1      err_total > err_thresh; valid from done, held
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE; in_ready, busy, done, fail = 0; word_cnt, err_total, max_dist,
//    internal dist/stage regs = 0. Sampled frame_len/err_thresh regs = 0.
//  - FSM states: IDLE, RUN, FLUSH, DONE.
//    - IDLE/DONE --start & frame_len!=0--> RUN. Same edge: clear word_cnt, err_total, max_dist, fail; latch frame_len, err_thresh.
//    - IDLE/DONE --start & frame_len==0--> DONE. Counters cleared, fail=(0>err_thresh)=0; done pulses next cycle.
//    - RUN --accept of pair number frame_len--> FLUSH.
//    - FLUSH --(1 cycle)--> DONE, done=1 for that cycle only.
//    - DONE holds all results until the next accepted start; no timeout.
//  - in_ready = (state==RUN), combinational from state only, never from in_valid.
//  - Accept = in_valid & in_ready.
//    - On accept, word_cnt increments.
//    - dist_q <= bit_com(info_bits, esti_bits); stage valid v_q <= 1.
//    - Words not accepted do not affect results.
//  - Pipeline: one register stage. A pair accepted in cycle t is added to err_total / max_dist at the end of t+1.
//  - Accumulation: err_total <= sat(err_total + dist_q), clamped at 2^ERR_W-1; no wrap.
//    max_dist <= max(max_dist, dist_q).
//  - Latency: last pair accepted in cycle t -> FLUSH in t+1 (final add) -> done=1 and fail valid in t+2.
//  - fail is computed on the FLUSH->DONE edge from the final err_total; it updates nowhere else except clear-on-start.
//  - busy = state in {RUN, FLUSH}.
//  - start in RUN/FLUSH is ignored: no restart, latched regs unchanged.
//  - start in the same cycle done=1: accepted; the new frame begins and done still completes its one-cycle pulse.
//  - Back-to-back accepts every cycle are legal at full rate; in_valid gaps only stall the count.
//  - reset_n low mid-frame: immediate return to IDLE with all outputs at reset values; the partial frame is lost.
//  - Simultaneous accept of the last word and a pending stage add: both commit, no lost update.
// TESTING
//  1. Reset, start, frame_len=4, thresh=5. Pairs (FFF,FFF), (000,001), (0F0,00F), (AAA,555), one per cycle.
//     -> err_total=0+1+8+12=21, max_dist=12, word_cnt=4, fail=1. done 2 cycles after the 4th accept.
//  2. frame_len=3, thresh=10, in_valid toggled 1,0,0,1,0,1, each pair dist=3.
//     -> in_ready stays 1, err_total=9, fail=0, word_cnt=3; extra valid after the 3rd accept is not taken (in_ready=0).
//  3. start with frame_len=0 -> busy never 1, done pulses the next cycle, err_total=0, word_cnt=0, max_dist=0.
//  4. ERR_W=4 build, frame_len=3, dist 12,12,12 -> err_total saturates at 15, not 4 (36 mod 16).
//  5. start again during RUN after 2 of 5 words -> ignored; frame ends at 5 words with original thresh.
//     Then reset_n=0 mid next frame -> all outputs 0 asynchronously, state IDLE.
//  6. start asserted in the done cycle with frame_len=2 -> new frame runs, prior results cleared on that edge,
//     done pulse exactly one cycle wide.

Source files
------------

// File: rtl/ber_frame_ctrl.sv
// Frame-level bit-error controller: accepts (info, estimate) word pairs, accumulates
// per-frame Hamming distance total and worst-word distance, and issues a pass/fail verdict.

module bit_com (
  input  logic [11:0] i_info,
  input  logic [11:0] i_esti,
  output logic [3:0]  o_dist_c
);

  logic [11:0] w_diff;

  assign w_diff = i_info ^ i_esti;

  // Population count of the differing bits
  always_comb begin
    o_dist_c = 4'd0;
    for (int i = 0; i < 12; i++) begin
      o_dist_c = o_dist_c + 4'(w_diff[i]);
    end
  end

endmodule

module ber_frame_ctrl #(
  parameter int unsigned WORD_W = 12,
  parameter int unsigned LEN_W  = 10,
  parameter int unsigned ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [ERR_W-1:0]  err_thresh,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] info_bits,
  input  logic [WORD_W-1:0] esti_bits,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  word_cnt,
  output logic [ERR_W-1:0]  err_total,
  output logic [3:0]        max_dist,
  output logic              fail
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_start_ok;
  logic [3:0]         w_dist;
  logic [LEN_W-1:0]   w_cnt_inc;
  logic [ERR_W:0]     w_sum;
  logic [ERR_W-1:0]   w_err_next;

  logic [LEN_W-1:0]   r_frame_len;
  logic [ERR_W-1:0]   r_thresh;
  logic [LEN_W-1:0]   r_word_cnt;
  logic [ERR_W-1:0]   r_err_total;
  logic [3:0]         r_max_dist;
  logic [3:0]         r_dist;
  logic               r_v;
  logic               r_done;
  logic               r_fail;

  bit_com u_bit_com (
    .i_info   (info_bits),
    .i_esti   (esti_bits),
    .o_dist_c (w_dist)
  );

  assign w_cnt_inc = r_word_cnt + LEN_W'(1);

  // Saturating add of the staged distance; this is also the final value used for the verdict
  assign w_sum      = {1'b0, r_err_total} + (ERR_W+1)'(r_dist);
  assign w_err_next = !r_v        ? r_err_total :
                      w_sum[ERR_W] ? {ERR_W{1'b1}} : w_sum[ERR_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_start_ok = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_start_ok = 1'b1;
          w_next     = (frame_len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        w_accept = in_valid;
        if (in_valid && (w_cnt_inc == r_frame_len)) begin
          w_next = S_FLUSH;
        end
      end
      S_FLUSH: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_len <= '0;
      r_thresh    <= '0;
      r_word_cnt  <= '0;
      r_err_total <= '0;
      r_max_dist  <= '0;
      r_dist      <= '0;
      r_v         <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_done <= (r_state == S_FLUSH) || (w_start_ok && (frame_len == '0));
      r_v    <= w_accept;
      if (w_accept) begin
        r_dist <= w_dist;
      end
      if (w_start_ok) begin
        r_frame_len <= frame_len;
        r_thresh    <= err_thresh;
        r_word_cnt  <= '0;
        r_err_total <= '0;
        r_max_dist  <= '0;
        r_fail      <= 1'b0;
      end else begin
        if (w_accept) begin
          r_word_cnt <= w_cnt_inc;
        end
        r_err_total <= w_err_next;
        if (r_v && (r_dist > r_max_dist)) begin
          r_max_dist <= r_dist;
        end
        if (r_state == S_FLUSH) begin
          r_fail <= (w_err_next > r_thresh);
        end
      end
    end
  end

  assign in_ready  = (r_state == S_RUN);
  assign busy      = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign done      = r_done;
  assign word_cnt  = r_word_cnt;
  assign err_total = r_err_total;
  assign max_dist  = r_max_dist;
  assign fail      = r_fail;

endmodule

// File: tb/tb_ber_frame_ctrl.sv
// Directed self-checking bench for ber_frame_ctrl, including a 4-bit accumulator build.

module tb_ber_frame_ctrl;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [9:0]  frame_len;
  logic [15:0] err_thresh;
  logic        in_valid;
  logic [11:0] info_bits;
  logic [11:0] esti_bits;

  logic        in_ready, busy, done, fail;
  logic [9:0]  word_cnt;
  logic [15:0] err_total;
  logic [3:0]  max_dist;

  logic        s_in_ready, s_busy, s_done, s_fail;
  logic [9:0]  s_word_cnt;
  logic [3:0]  s_err_total;
  logic [3:0]  s_max_dist;

  int checks = 0;
  int errors = 0;

  ber_frame_ctrl #(.WORD_W(12), .LEN_W(10), .ERR_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .frame_len(frame_len),
    .err_thresh(err_thresh), .in_valid(in_valid), .in_ready(in_ready),
    .info_bits(info_bits), .esti_bits(esti_bits), .busy(busy), .done(done),
    .word_cnt(word_cnt), .err_total(err_total), .max_dist(max_dist), .fail(fail)
  );

  ber_frame_ctrl #(.WORD_W(12), .LEN_W(10), .ERR_W(4)) u_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .frame_len(frame_len),
    .err_thresh(err_thresh[3:0]), .in_valid(in_valid), .in_ready(s_in_ready),
    .info_bits(info_bits), .esti_bits(esti_bits), .busy(s_busy), .done(s_done),
    .word_cnt(s_word_cnt), .err_total(s_err_total), .max_dist(s_max_dist), .fail(s_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; frame_len = '0; err_thresh = '0;
    in_valid = 1'b0; info_bits = '0; esti_bits = '0;
    step(); step();
    reset_n = 1'b1;
    step();
    checks++;
    if ({in_ready, busy, done, fail} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {in_ready, busy, done, fail});
    end
    checks++;
    if ({word_cnt, err_total, max_dist} !== 30'd0) begin
      errors++; $display("FAIL reset_counts got cnt=%0d err=%0d max=%0d want 0", word_cnt, err_total, max_dist);
    end
  endtask

  task automatic test_basic();
    logic [11:0] inf [4];
    logic [11:0] est [4];
    inf[0] = 12'hFFF; est[0] = 12'hFFF;
    inf[1] = 12'h000; est[1] = 12'h001;
    inf[2] = 12'h0F0; est[2] = 12'h00F;
    inf[3] = 12'hAAA; est[3] = 12'h555;
    start = 1'b1; frame_len = 10'd4; err_thresh = 16'd5;
    step();
    start = 1'b0;
    checks++;
    if ({busy, in_ready} !== 2'b11) begin
      errors++; $display("FAIL basic_run got busy=%b rdy=%b want 1 1", busy, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; info_bits = inf[i]; esti_bits = est[i];
      step();
      if (i == 2) begin
        checks++;
        if (err_total !== 16'd1) begin
          errors++; $display("FAIL basic_latency got err=%0d want 1", err_total);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if ({in_ready, busy, done} !== 3'b010 || word_cnt !== 10'd4 || err_total !== 16'd9) begin
      errors++; $display("FAIL basic_flush got rdy=%b busy=%b done=%b cnt=%0d err=%0d want 0 1 0 4 9",
                         in_ready, busy, done, word_cnt, err_total);
    end
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err_total !== 16'd21 || max_dist !== 4'd12 ||
        word_cnt !== 10'd4 || fail !== 1'b1) begin
      errors++; $display("FAIL basic_done got done=%b busy=%b err=%0d max=%0d cnt=%0d fail=%b want 1 0 21 12 4 1",
                         done, busy, err_total, max_dist, word_cnt, fail);
    end
    step();
    checks++;
    if (done !== 1'b0 || err_total !== 16'd21 || fail !== 1'b1) begin
      errors++; $display("FAIL basic_hold got done=%b err=%0d fail=%b want 0 21 1", done, err_total, fail);
    end
  endtask

  task automatic test_gaps();
    logic [5:0] pat;
    pat = 6'b101001;
    start = 1'b1; frame_len = 10'd3; err_thresh = 16'd10;
    info_bits = 12'h007; esti_bits = 12'h000;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = pat[i];
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL gaps_ready[%0d] got %b want 1", i, in_ready);
      end
      step();
    end
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL gaps_extra_ready got %b want 0", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || err_total !== 16'd9 || fail !== 1'b0 || word_cnt !== 10'd3 || max_dist !== 4'd3) begin
      errors++; $display("FAIL gaps_done got done=%b err=%0d fail=%b cnt=%0d max=%0d want 1 9 0 3 3",
                         done, err_total, fail, word_cnt, max_dist);
    end
    step();
  endtask

  task automatic test_zero_len();
    start = 1'b1; frame_len = 10'd0; err_thresh = 16'd0;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err_total !== 16'd0 || word_cnt !== 10'd0 ||
        max_dist !== 4'd0 || fail !== 1'b0) begin
      errors++; $display("FAIL zero_done got done=%b busy=%b err=%0d cnt=%0d max=%0d fail=%b want 1 0 0 0 0 0",
                         done, busy, err_total, word_cnt, max_dist, fail);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_after got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_saturate();
    start = 1'b1; frame_len = 10'd3; err_thresh = 16'd20;
    info_bits = 12'hAAA; esti_bits = 12'h555;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    step(); step(); step();
    in_valid = 1'b0;
    step();
    checks++;
    if (s_done !== 1'b1 || s_err_total !== 4'd15 || s_max_dist !== 4'd12 || s_fail !== 1'b1) begin
      errors++; $display("FAIL sat_narrow got done=%b err=%0d max=%0d fail=%b want 1 15 12 1",
                         s_done, s_err_total, s_max_dist, s_fail);
    end
    checks++;
    if (done !== 1'b1 || err_total !== 16'd36 || fail !== 1'b1) begin
      errors++; $display("FAIL sat_wide got done=%b err=%0d fail=%b want 1 36 1", done, err_total, fail);
    end
    step();
  endtask

  task automatic test_restart_ignored();
    start = 1'b1; frame_len = 10'd5; err_thresh = 16'd7;
    info_bits = 12'h003; esti_bits = 12'h000;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    step(); step();
    start = 1'b1; frame_len = 10'd1; err_thresh = 16'd100;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || word_cnt !== 10'd3) begin
      errors++; $display("FAIL restart_run got busy=%b cnt=%0d want 1 3", busy, word_cnt);
    end
    step(); step();
    in_valid = 1'b0;
    step();
    checks++;
    if (done !== 1'b1 || word_cnt !== 10'd5 || err_total !== 16'd10 || fail !== 1'b1) begin
      errors++; $display("FAIL restart_done got done=%b cnt=%0d err=%0d fail=%b want 1 5 10 1",
                         done, word_cnt, err_total, fail);
    end
    // Abort the next frame with an asynchronous reset mid-cycle
    step();
    start = 1'b1; frame_len = 10'd4; err_thresh = 16'd0;
    step();
    start = 1'b0; in_valid = 1'b1;
    step(); step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, done, fail} !== 4'b0000 || word_cnt !== 10'd0 || err_total !== 16'd0 ||
        max_dist !== 4'd0) begin
      errors++; $display("FAIL async_reset got rdy=%b busy=%b done=%b fail=%b cnt=%0d err=%0d max=%0d want all 0",
                         in_ready, busy, done, fail, word_cnt, err_total, max_dist);
    end
    in_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle got rdy=%b busy=%b want 0 0", in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; frame_len = 10'd2; err_thresh = 16'd0;
    info_bits = 12'h001; esti_bits = 12'h000;
    step();
    start = 1'b0; in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    step();
    checks++;
    if (done !== 1'b1 || err_total !== 16'd2 || fail !== 1'b1) begin
      errors++; $display("FAIL b2b_first got done=%b err=%0d fail=%b want 1 2 1", done, err_total, fail);
    end
    start = 1'b1; frame_len = 10'd2; err_thresh = 16'd3;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || err_total !== 16'd0 || word_cnt !== 10'd0 ||
        max_dist !== 4'd0 || fail !== 1'b0) begin
      errors++; $display("FAIL b2b_clear got done=%b busy=%b err=%0d cnt=%0d max=%0d fail=%b want 0 1 0 0 0 0",
                         done, busy, err_total, word_cnt, max_dist, fail);
    end
    info_bits = 12'h00C; esti_bits = 12'h000; in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    step();
    checks++;
    if (done !== 1'b1 || err_total !== 16'd4 || max_dist !== 4'd2 || word_cnt !== 10'd2 || fail !== 1'b1) begin
      errors++; $display("FAIL b2b_second got done=%b err=%0d max=%0d cnt=%0d fail=%b want 1 4 2 2 1",
                         done, err_total, max_dist, word_cnt, fail);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL b2b_pulse got done=%b want 0", done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_zero_len();
    test_saturate();
    test_restart_ignored();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
